// File: rtl/instr_encoder.sv
// RV32I instruction packer: decoded fields plus a 32-bit immediate -> instruction word, two-stage valid/ready pipeline.
// Defining INSTR_ENCODER_ROUNDTRIP_CHECK_EN builds the immediate round-trip compare that drives rt_mismatch.
module instr_encoder #(
    parameter int COUNT_W = 16,
    parameter int ERR_NOP = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         fmt,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic [31:0]        imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        instr,
    output logic [1:0]         err,
    output logic [COUNT_W-1:0] enc_count,
    output logic               rt_mismatch
);

    localparam logic [2:0] FMT_I   = 3'b000;
    localparam logic [2:0] FMT_U   = 3'b001;
    localparam logic [2:0] FMT_S   = 3'b010;
    localparam logic [2:0] FMT_J   = 3'b011;
    localparam logic [2:0] FMT_B   = 3'b100;
    localparam logic [2:0] FMT_R   = 3'b101;
    localparam logic [2:0] FMT_I2  = 3'b110;
    localparam logic [2:0] FMT_RSV = 3'b111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // err[0]: immediate not representable; err[1]: misaligned branch/jump target or reserved format
    function automatic logic [1:0] imm_err(input logic [2:0] f, input logic signed [31:0] v);
        logic [1:0] e;
        e = 2'b00;
        case (f)
            FMT_I, FMT_I2, FMT_S: e[0] = !in_range(v, -32'sd2048, 32'sd2047);
            FMT_B: begin
                e[0] = !in_range(v, -32'sd4096, 32'sd4094);
                e[1] = v[0];
            end
            FMT_J: begin
                e[0] = !in_range(v, -32'sd1048576, 32'sd1048574);
                e[1] = v[0];
            end
            FMT_U:   e[0] = (v[11:0] != 12'd0);
            FMT_RSV: e = 2'b10;
            default: e = 2'b00;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pack_word(input logic [2:0]  f,
                                              input logic [6:0]  op,
                                              input logic [4:0]  d,
                                              input logic [4:0]  s1,
                                              input logic [4:0]  s2,
                                              input logic [2:0]  f3,
                                              input logic [6:0]  f7,
                                              input logic [31:0] v);
        logic [31:0] w;
        case (f)
            FMT_I, FMT_I2: w = {v[11:0], s1, f3, d, op};
            FMT_U:         w = {v[31:12], d, op};
            FMT_S:         w = {v[11:5], s2, s1, f3, v[4:0], op};
            FMT_J:         w = {v[20], v[10:1], v[11], v[19:12], d, op};
            FMT_B:         w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
            FMT_R:         w = {f7, s2, s1, f3, d, op};
            default:       w = 32'd0;
        endcase
        return w;
    endfunction

    logic               vld_p1;
    logic [2:0]         fmt_p1;
    logic [6:0]         opcode_p1;
    logic [4:0]         rd_p1;
    logic [4:0]         rs1_p1;
    logic [4:0]         rs2_p1;
    logic [2:0]         funct3_p1;
    logic [6:0]         funct7_p1;
    logic signed [31:0] imm_p1;

    logic [31:0]        packed_p1;
    logic [31:0]        word_p1;
    logic [1:0]         err_p1;
    logic               rt_p1;

    logic               vld_p2;
    logic [31:0]        instr_p2;
    logic [1:0]         err_p2;
    logic [COUNT_W-1:0] count_q;

    logic load_p2;
    logic accept;
    logic handoff;

    // S2 can take a word whenever it is empty or draining this cycle; S1 follows it
    assign load_p2  = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || load_p2;
    assign accept   = in_valid && in_ready;
    assign handoff  = vld_p2 && out_ready;

    // ---- stage 1: capture fields ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fmt_p1    <= fmt;
            opcode_p1 <= opcode;
            rd_p1     <= rd;
            rs1_p1    <= rs1;
            rs2_p1    <= rs2;
            funct3_p1 <= funct3;
            funct7_p1 <= funct7;
            imm_p1    <= imm;
        end
    end

    always_comb begin
        packed_p1 = pack_word(fmt_p1, opcode_p1, rd_p1, rs1_p1, rs2_p1,
                              funct3_p1, funct7_p1, imm_p1);
        err_p1    = imm_err(fmt_p1, imm_p1);
        word_p1   = packed_p1;
        if ((ERR_NOP != 0) && (err_p1 != 2'b00)) begin
            word_p1 = NOP_WORD;
        end
    end

`ifdef INSTR_ENCODER_ROUNDTRIP_CHECK_EN
    // Immediate generator's decode of a packed word; LSB forced to zero for B/J
    function automatic logic [31:0] extract_imm(input logic [2:0] f, input logic [31:0] w);
        logic [31:0] v;
        case (f)
            FMT_I, FMT_I2: v = {{20{w[31]}}, w[31:20]};
            FMT_U:         v = {w[31:12], 12'd0};
            FMT_S:         v = {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:         v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_J:         v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:       v = 32'd0;
        endcase
        return v;
    endfunction

    assign rt_p1 = (err_p1 == 2'b00) && (fmt_p1 != FMT_R) && (fmt_p1 != FMT_RSV) &&
                   (extract_imm(fmt_p1, packed_p1) != $unsigned(imm_p1));

    logic rt_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rt_p2 <= 1'b0;
        end else if (load_p2 && vld_p1) begin
            rt_p2 <= rt_p1;
        end
    end

    assign rt_mismatch = rt_p2;
`else
    assign rt_p1       = 1'b0;
    assign rt_mismatch = rt_p1;
`endif

    // ---- stage 2: output word register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2   <= 1'b0;
            instr_p2 <= 32'd0;
            err_p2   <= 2'b00;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                instr_p2 <= word_p1;
                err_p2   <= err_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (handoff) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign out_valid = vld_p2;
    assign instr     = instr_p2;
    assign err       = err_p2;
    assign enc_count = count_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs decoded RV32I instruction fields plus a 32-bit immediate back into a 32-bit instruction word.
- This is the inverse of the immediate generator: it uses the same 3-bit format code and the same bit placements.
- Sits in the test and self-check infrastructure. It feeds instruction memories and scoreboards, and checks whether an immediate is representable.
- Two-stage valid/ready pipeline with an encoded-word counter.

Parameters:
- COUNT_W, 16: width of the enc_count wrap-around counter.
- ERR_NOP, 0: when 1, any word flagged with an error is replaced by 32'h00000013 (addi x0,x0,0).

Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-high.
- in_valid  in  1: input fields valid.
- in_ready  out  1: encoder can accept.
- fmt  in  3: 000 I, 110 I (alt; same packing as 000), 001 U, 010 S, 011 J, 100 B, 101 R, 111 reserved.
- opcode  in  7: placed in instr[6:0].
- rd  in  5: [11:7] for I/U/J/R.
- rs1  in  5: [19:15] for I/S/B/R.
- rs2  in  5: [24:20] for S/B/R.
- funct3  in  3: [14:12] for I/S/B/R.
- funct7  in  7: [31:25] for R.
- imm  in  32: full signed or absolute immediate value.
- out_valid  out  1: instr valid.
- out_ready  in  1: consumer accepts.
- instr  out  32: encoded word.
- err  out  2: bit0 = range error, bit1 = alignment or reserved-format error; qualified by out_valid.
- enc_count  out  COUNT_W: number of words handed off.
- rt_mismatch  out  1: round-trip check failure (see Optional Feature).

Behaviour:
- Reset (synchronous) values: out_valid=0, instr=0, err=0, enc_count=0, rt_mismatch=0, both stage-valid flags 0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight words. No handoff occurs and enc_count does not increment in the reset cycle.
- Stage 1 (S1): registers the fields on in_valid&&in_ready and computes err from the registered imm.
- Stage 2 (S2): registers the packed word and err. instr, err and out_valid are driven straight from S2 registers.
- Stall rules:
  - S2 loads when !s2_valid || out_ready.
  - S1 advances when it can load S2.
  - in_ready = !s1_valid || S1 advances.
  - This is combinational on out_ready; there are no bubbles under full throughput.
- Latency: 2 cycles from accept edge to out_valid with out_ready=1. Throughput is 1 word per cycle.
- Handoff is out_valid&&out_ready. Under stall, instr and err are held stable. Words are never dropped or reordered.
- Packing:
  - I (000/110): {imm[11:0],rs1,funct3,rd,opcode}.
  - U: {imm[31:12],rd,opcode}.
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
  - R: {funct7,rs2,rs1,funct3,rd,opcode}; imm is ignored and err=0.
  - Reserved (111): instr=0, err=2'b10.
- Range rule err[0] (signed imm):
  - I/S: outside [-2048, 2047].
  - B: outside [-4096, 4094].
  - J: outside [-1048576, 1048574].
  - U: imm[11:0] != 0.
- Alignment rule err[1]: B or J with imm[0]=1.
- On error, bits are packed truncated as above, unless ERR_NOP=1, in which case instr=32'h00000013.
- enc_count increments by 1 on each handoff and wraps from 2^COUNT_W-1 to 0.

Optional Feature:
- Macro: INSTR_ENCODER_ROUNDTRIP_CHECK_EN.
- When defined:
  - S2 re-extracts the immediate from the packed word using the immediate generator's rules: I/U/S/J/B sign-extension and zero LSB.
  - For words with err=0 and fmt not R or reserved, the extracted value is compared with the S1 imm.
  - rt_mismatch is registered with the word and is set on inequality.
- When undefined: rt_mismatch is tied to 0 and no compare logic is built.

Test Plan:
- I: fmt=000, opcode=0010011, rd=1, rs1=0, funct3=0, imm=32'hFFFFFFFF, out_ready=1 -> instr=32'hFFF00093 and err=0, with out_valid exactly 2 cycles after accept; enc_count=1.
- B: fmt=100, opcode=1100011, rs1=1, rs2=2, funct3=0, imm=-4 -> instr=32'hFE208EE3, err=0, rt_mismatch=0.
- U and errors:
  - fmt=001, opcode=0110111, rd=5, imm=32'h12345000 -> instr=32'h123452B7.
  - Same with imm=32'h12345001 -> err=2'b01.
  - J with imm=3 -> err=2'b10.
  - I with imm=2048 and ERR_NOP=1 -> instr=32'h00000013, err=2'b01.
- Backpressure: out_ready=0 for 5 cycles while 3 back-to-back words are offered -> exactly 2 accepted and in_ready=0 afterwards; instr held stable. On release, the 3 words come out in order and enc_count=3.
- Reset: assert reset for 1 cycle with both stages full -> next cycle out_valid=0, enc_count=0, in_ready=1; no stale word emerges afterwards.
- Wrap: COUNT_W=4, 17 handoffs -> enc_count=1.
